// File: rtl/pio_pulse_master_if.sv
// Avalon-MM bus between the pulse master and an output-PIO slave.
// Single-cycle accesses, no waitrequest; readdata is combinational.
interface pio_pulse_master_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_pulse_master.sv
// Pulses selected output-PIO bits for a programmed hold time and verifies the
// slave by reading the data register back after both the set and clear writes.
module pio_pulse_master #(
  parameter int CNT_W     = 16,
  parameter int ADDR_DATA = 0,
  parameter int ADDR_SET  = 4,
  parameter int ADDR_CLR  = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [31:0]          pulse_mask,
  input  logic [CNT_W-1:0]     pulse_len,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  pio_pulse_master_if.master   bus
);

  typedef enum logic [2:0] {IDLE, SET, RD1, HOLD, CLR, RD2, DONE} state_t;

  state_t           state, state_nx;
  logic [31:0]      mask_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // HOLD is entered with cnt=len>=1; leaving when cnt==1 gives exactly len
  // HOLD cycles and the counter never wraps.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = SET;
      SET:  state_nx = RD1;
      RD1:  state_nx = (len_q == '0) ? CLR : HOLD;
      HOLD: if (cnt == CNT_W'(1)) state_nx = CLR;
      CLR:  state_nx = RD2;
      RD2:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q         <= '0;
      len_q          <= '0;
      cnt            <= '0;
      error          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.chipselect <= 1'b0;
      bus.write_n    <= 1'b1;
      bus.address    <= '0;
      bus.writedata  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mask_q <= pulse_mask;
          len_q  <= pulse_len;
          error  <= 1'b0;
        end
        RD1: begin
          cnt <= len_q;
          if ((bus.readdata & mask_q) != mask_q) error <= 1'b1;
        end
        HOLD: cnt <= cnt - CNT_W'(1);
        RD2: if ((bus.readdata & mask_q) != '0) error <= 1'b1;
        default: ;
      endcase

      // Bus and status outputs are registered from the next state so each
      // access occupies exactly the cycle its state is active.
      busy           <= state_nx inside {SET, RD1, HOLD, CLR, RD2};
      done           <= (state_nx == DONE);
      bus.chipselect <= state_nx inside {SET, RD1, CLR, RD2};
      bus.write_n    <= !(state_nx inside {SET, CLR});
      case (state_nx)
        SET: begin
          bus.address   <= 3'(ADDR_SET);
          bus.writedata <= (state == IDLE) ? pulse_mask : mask_q;
        end
        CLR: begin
          bus.address   <= 3'(ADDR_CLR);
          bus.writedata <= mask_q;
        end
        RD1, RD2: bus.address <= 3'(ADDR_DATA);
        default: ;
      endcase
    end
  end

endmodule
